// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multicycle MIPS main controller: opcodes, FSM states,
// datapath mux codes and the packed control word produced by the output decoder.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        R_EXEC    = 4'd6,
        R_WB      = 4'd7,
        BRANCH    = 4'd8,
        JUMP      = 4'd9,
        I_EXEC    = 4'd10,
        I_WB      = 4'd11,
        TRAP      = 4'd12
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_B       = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

    typedef struct packed {
        logic       pc_write_cond;
        logic       pc_write;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
    } ctrl_t;

endpackage

// File: rtl/mips_ctrl_outdec.sv
// Combinational state -> control-word decoder. Moore apart from the FETCH
// PC/IR writes, which wait for mem_ready. en=0 forces every control low.
module mips_ctrl_outdec
    import mips_ctrl_pkg::*;
(
    input  state_t state,
    input  logic   mem_ready,
    input  logic   en,
    output ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        if (en) begin
            case (state)
                FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.alu_op    = ALUOP_ADD;
                    ctrl.pc_source = PCSRC_ALU;
                    ctrl.ir_write  = mem_ready;
                    ctrl.pc_write  = mem_ready;
                end
                DECODE: begin
                    ctrl.alu_src_b = SRCB_IMM_SH2;
                    ctrl.alu_op    = ALUOP_ADD;
                end
                MEM_ADDR, I_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALUOP_ADD;
                end
                MEM_READ: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.i_or_d   = 1'b1;
                end
                MEM_WB: begin
                    ctrl.reg_write  = 1'b1;
                    ctrl.mem_to_reg = 1'b1;
                end
                MEM_WRITE: begin
                    ctrl.mem_write = 1'b1;
                    ctrl.i_or_d    = 1'b1;
                end
                R_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_B;
                    ctrl.alu_op    = ALUOP_FUNCT;
                end
                R_WB: begin
                    ctrl.reg_write = 1'b1;
                    ctrl.reg_dst   = 1'b1;
                end
                BRANCH: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_src_b     = SRCB_B;
                    ctrl.alu_op        = ALUOP_SUB;
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_source     = PCSRC_ALUOUT;
                end
                JUMP: begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PCSRC_JUMP;
                end
                I_WB: begin
                    ctrl.reg_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS main control FSM with mem_ready handshake and ADDI support.
// Optional MIPS_CTRL_TRAP_EN: undecoded opcodes lock in TRAP and raise illegal_op.
module mips_multicycle_ctrl
    import mips_ctrl_pkg::*;
#(
    parameter int OPW    = 6,
    parameter int ALUOPW = 2,
    parameter int STATEW = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [OPW-1:0]    opcode,
    input  logic              mem_ready,
    output logic              PCWriteCond,
    output logic              PCWrite,
    output logic              IorD,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              MemtoReg,
    output logic              IRWrite,
    output logic              RegDst,
    output logic              RegWrite,
    output logic              ALUSrcA,
    output logic [1:0]        ALUSrcB,
    output logic [ALUOPW-1:0] ALUOp,
    output logic [1:0]        PCSource,
    output logic [STATEW-1:0] state
`ifdef MIPS_CTRL_TRAP_EN
    ,
    output logic              illegal_op
`endif
);

    state_t         state_q;
    state_t         state_d;
    logic [OPW-1:0] op_q;
    ctrl_t          ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == DECODE) begin
                op_q <= opcode;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:     if (mem_ready) state_d = DECODE;
            DECODE: begin
                if (opcode == OPW'(OP_RTYPE)) begin
                    state_d = R_EXEC;
                end else if (opcode == OPW'(OP_LW) || opcode == OPW'(OP_SW)) begin
                    state_d = MEM_ADDR;
                end else if (opcode == OPW'(OP_BEQ)) begin
                    state_d = BRANCH;
                end else if (opcode == OPW'(OP_J)) begin
                    state_d = JUMP;
                end else if (opcode == OPW'(OP_ADDI)) begin
                    state_d = I_EXEC;
                end else begin
`ifdef MIPS_CTRL_TRAP_EN
                    state_d = TRAP;
`else
                    state_d = FETCH;
`endif
                end
            end
            // Live opcode is ignored here; only the copy taken in DECODE counts.
            MEM_ADDR:  state_d = (op_q == OPW'(OP_LW)) ? MEM_READ : MEM_WRITE;
            MEM_READ:  if (mem_ready) state_d = MEM_WB;
            MEM_WB:    state_d = FETCH;
            MEM_WRITE: if (mem_ready) state_d = FETCH;
            R_EXEC:    state_d = R_WB;
            R_WB:      state_d = FETCH;
            BRANCH:    state_d = FETCH;
            JUMP:      state_d = FETCH;
            I_EXEC:    state_d = I_WB;
            I_WB:      state_d = FETCH;
`ifdef MIPS_CTRL_TRAP_EN
            TRAP:      state_d = TRAP;
`endif
            default:   state_d = FETCH;
        endcase
    end

    // Gating with rst_n keeps FETCH's MemRead low for as long as reset is held.
    mips_ctrl_outdec u_outdec (
        .state     (state_q),
        .mem_ready (mem_ready),
        .en        (rst_n),
        .ctrl      (ctrl)
    );

    assign PCWriteCond = ctrl.pc_write_cond;
    assign PCWrite     = ctrl.pc_write;
    assign IorD        = ctrl.i_or_d;
    assign MemRead     = ctrl.mem_read;
    assign MemWrite    = ctrl.mem_write;
    assign MemtoReg    = ctrl.mem_to_reg;
    assign IRWrite     = ctrl.ir_write;
    assign RegDst      = ctrl.reg_dst;
    assign RegWrite    = ctrl.reg_write;
    assign ALUSrcA     = ctrl.alu_src_a;
    assign ALUSrcB     = ctrl.alu_src_b;
    assign ALUOp       = ALUOPW'(ctrl.alu_op);
    assign PCSource    = ctrl.pc_source;
    assign state       = STATEW'(state_q);

`ifdef MIPS_CTRL_TRAP_EN
    assign illegal_op = (state_q == TRAP);
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: per-cycle expected state/control words
// are queued as each cycle is driven and popped when the outputs are sampled.
module tb_mips_multicycle_ctrl;

    localparam logic [3:0] ST_FETCH = 4'd0,  ST_DECODE = 4'd1,  ST_MADDR = 4'd2,
                           ST_MREAD = 4'd3,  ST_MWB    = 4'd4,  ST_MWRITE = 4'd5,
                           ST_REXEC = 4'd6,  ST_RWB    = 4'd7,  ST_BRANCH = 4'd8,
                           ST_JUMP  = 4'd9,  ST_IEXEC  = 4'd10, ST_IWB    = 4'd11,
                           ST_TRAP  = 4'd12;

    typedef struct {
        logic [3:0] st;
        logic       mr;
    } step_t;

    typedef struct {
        logic [3:0]  st;
        logic [15:0] ctl;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, RegDst, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;
`ifdef MIPS_CTRL_TRAP_EN
    logic       illegal_op;
`endif

    int   n_pass = 0;
    int   n_total = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    mips_multicycle_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .PCWriteCond (PCWriteCond),
        .PCWrite     (PCWrite),
        .IorD        (IorD),
        .MemRead     (MemRead),
        .MemWrite    (MemWrite),
        .MemtoReg    (MemtoReg),
        .IRWrite     (IRWrite),
        .RegDst      (RegDst),
        .RegWrite    (RegWrite),
        .ALUSrcA     (ALUSrcA),
        .ALUSrcB     (ALUSrcB),
        .ALUOp       (ALUOp),
        .PCSource    (PCSource),
        .state       (state)
`ifdef MIPS_CTRL_TRAP_EN
        ,
        .illegal_op  (illegal_op)
`endif
    );

    function automatic logic [15:0] obs_ctl();
        return {PCWriteCond, PCWrite, IorD, MemRead, MemWrite, MemtoReg, IRWrite,
                RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource};
    endfunction

    function automatic logic [15:0] exp_ctl(input logic [3:0] st, input logic mr);
        logic pcc, pcw, iord, mrd, mwr, m2r, irw, rdst, rw, asa;
        logic [1:0] asb, aop, psrc;
        {pcc, pcw, iord, mrd, mwr, m2r, irw, rdst, rw, asa} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            ST_FETCH:  begin mrd = 1'b1; asb = 2'b01; irw = mr; pcw = mr; end
            ST_DECODE: asb = 2'b11;
            ST_MADDR:  begin asa = 1'b1; asb = 2'b10; end
            ST_MREAD:  begin mrd = 1'b1; iord = 1'b1; end
            ST_MWB:    begin rw = 1'b1; m2r = 1'b1; end
            ST_MWRITE: begin mwr = 1'b1; iord = 1'b1; end
            ST_REXEC:  begin asa = 1'b1; aop = 2'b10; end
            ST_RWB:    begin rw = 1'b1; rdst = 1'b1; end
            ST_BRANCH: begin asa = 1'b1; aop = 2'b01; pcc = 1'b1; psrc = 2'b01; end
            ST_JUMP:   begin pcw = 1'b1; psrc = 2'b10; end
            ST_IEXEC:  begin asa = 1'b1; asb = 2'b10; end
            ST_IWB:    rw = 1'b1;
            default: ;
        endcase
        return {pcc, pcw, iord, mrd, mwr, m2r, irw, rdst, rw, asa, asb, aop, psrc};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    endtask

    // Runs one instruction from FETCH; caller is positioned just after a rising edge.
    task automatic run_instr(input string tag, input logic [5:0] op, input int fetch_waits,
                             input int mem_waits, input int trap_cycles, output int ir_pulses);
        step_t steps[$];
        exp_t  e;
        ir_pulses = 0;
        for (int i = 0; i < fetch_waits; i++) steps.push_back('{ST_FETCH, 1'b0});
        steps.push_back('{ST_FETCH, 1'b1});
        steps.push_back('{ST_DECODE, 1'($urandom_range(0, 1))});
        case (op)
            6'b000000: begin
                steps.push_back('{ST_REXEC, 1'($urandom_range(0, 1))});
                steps.push_back('{ST_RWB, 1'($urandom_range(0, 1))});
            end
            6'b100011: begin
                steps.push_back('{ST_MADDR, 1'($urandom_range(0, 1))});
                for (int i = 0; i < mem_waits; i++) steps.push_back('{ST_MREAD, 1'b0});
                steps.push_back('{ST_MREAD, 1'b1});
                steps.push_back('{ST_MWB, 1'($urandom_range(0, 1))});
            end
            6'b101011: begin
                steps.push_back('{ST_MADDR, 1'($urandom_range(0, 1))});
                for (int i = 0; i < mem_waits; i++) steps.push_back('{ST_MWRITE, 1'b0});
                steps.push_back('{ST_MWRITE, 1'b1});
            end
            6'b000100: steps.push_back('{ST_BRANCH, 1'($urandom_range(0, 1))});
            6'b000010: steps.push_back('{ST_JUMP, 1'($urandom_range(0, 1))});
            6'b001000: begin
                steps.push_back('{ST_IEXEC, 1'($urandom_range(0, 1))});
                steps.push_back('{ST_IWB, 1'($urandom_range(0, 1))});
            end
            default:
                for (int i = 0; i < trap_cycles; i++)
                    steps.push_back('{ST_TRAP, 1'($urandom_range(0, 1))});
        endcase
        foreach (steps[i]) begin
            mem_ready = steps[i].mr;
            opcode    = (steps[i].st == ST_DECODE) ? op : 6'($urandom);
            sb.push_back('{steps[i].st, exp_ctl(steps[i].st, steps[i].mr)});
            @(negedge clk);
            e = sb.pop_front();
            chk($sformatf("%s_state_c%0d", tag, i), 32'(state), 32'(e.st));
            chk($sformatf("%s_ctl_c%0d", tag, i), 32'(obs_ctl()), 32'(e.ctl));
`ifdef MIPS_CTRL_TRAP_EN
            chk($sformatf("%s_illegal_c%0d", tag, i), 32'(illegal_op), 32'(e.st == ST_TRAP));
`endif
            ir_pulses += int'(IRWrite);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int irp;
        int k;
        rst_n = 1'b0;
        opcode = 6'b0;
        mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        mem_ready = 1'b1;
        #1;
        chk("reset_state", 32'(state), 32'(ST_FETCH));
        chk("reset_ctl", 32'(obs_ctl()), 32'h0);
`ifdef MIPS_CTRL_TRAP_EN
        chk("reset_illegal", 32'(illegal_op), 32'h0);
`endif
        rst_n = 1'b1;

        run_instr("r", 6'b000000, 0, 0, 0, irp);
        run_instr("lw", 6'b100011, 0, 0, 0, irp);

        // Reset dropped at a random point of an lw, possibly inside MEM_WB.
        opcode = 6'b100011;
        mem_ready = 1'b1;
        k = $urandom_range(1, 4);
        repeat (k) @(posedge clk);
        #($urandom_range(1, 8));
        rst_n = 1'b0;
        #1;
        chk("midlw_reset_state", 32'(state), 32'(ST_FETCH));
        chk("midlw_reset_ctl", 32'(obs_ctl()), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("midlw_release_state", 32'(state), 32'(ST_FETCH));
        chk("midlw_release_memread", 32'(MemRead), 32'h1);

        run_instr("lw_wait", 6'b100011, 3, 3, 0, irp);
        chk("lw_wait_irwrite_pulses", 32'(irp), 32'd1);
        run_instr("sw", 6'b101011, 0, 2, 0, irp);
        run_instr("beq", 6'b000100, 0, 0, 0, irp);
        run_instr("j", 6'b000010, 0, 0, 0, irp);
        run_instr("addi", 6'b001000, 1, 0, 0, irp);

`ifdef MIPS_CTRL_TRAP_EN
        run_instr("illegal", 6'b111111, 0, 0, 4, irp);
        rst_n = 1'b0;
        #1;
        chk("trap_reset_state", 32'(state), 32'(ST_FETCH));
        chk("trap_reset_illegal", 32'(illegal_op), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
`else
        run_instr("illegal", 6'b111111, 0, 0, 0, irp);
`endif
        run_instr("r_after", 6'b000000, 0, 0, 0, irp);
        run_instr("lw_end", 6'b100011, 0, 1, 0, irp);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
